// File: rtl/fifo_rdr_pkg.sv
// Shared types and defaults for the FiFo read-side master (fifo_reader).
// The optional frame marker on m_last is enabled by defining FIFO_RDR_LAST_EN.
package fifo_rdr_pkg;

  localparam int unsigned DATA_BUS_SIZE_DEF = 32;
  localparam int unsigned RD_LATENCY_DEF    = 2;
  localparam int unsigned BUF_DEPTH_DEF     = 2;
  localparam int unsigned FRAME_LEN_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } rdr_state_e;

  typedef logic [DATA_BUS_SIZE_DEF-1:0] word_t;

  // Counter/pointer width that stays at least one bit wide for n <= 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rdr_obuf.sv
// Circular output buffer for fifo_reader: push from the capture stage, pop on
// the downstream valid/ready handshake. Head word reads as zero while empty.
module fifo_rdr_obuf
  import fifo_rdr_pkg::*;
#(
  parameter int unsigned DW    = DATA_BUS_SIZE_DEF,
  parameter int unsigned DEPTH = BUF_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          valid_o,
  output logic          full_o
);

  localparam int unsigned PW = cnt_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] wr_en;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_i && valid_o;
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_i && (wr_ptr_q == PW'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_i && pop_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage has no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (wr_en[i]) begin
        mem_q[i] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for FiFo: paced rd/empt/data_out reads re-presented as a
// valid/ready stream. Define FIFO_RDR_LAST_EN to drive m_last every FRAME_LEN words.
module fifo_reader
  import fifo_rdr_pkg::*;
#(
  parameter int unsigned DATA_BUS_SIZE = DATA_BUS_SIZE_DEF,
  parameter int unsigned RD_LATENCY    = RD_LATENCY_DEF,
  parameter int unsigned BUF_DEPTH     = BUF_DEPTH_DEF,
  parameter int unsigned FRAME_LEN     = FRAME_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     fifo_rd,
  input  logic                     fifo_empt,
  input  logic [DATA_BUS_SIZE-1:0] fifo_data,
  output logic [DATA_BUS_SIZE-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy
);

  localparam int unsigned WW = cnt_width(RD_LATENCY);

  generate
    if (RD_LATENCY < 1 || BUF_DEPTH < 1 || FRAME_LEN < 1 ||
        (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_param_check
      $error("fifo_reader: illegal parameter set");
    end
  endgenerate

  rdr_state_e    state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          fifo_rd_q;
  logic          buf_full;
  logic          push;
  logic          pop;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        // Only one read is ever in flight, so checking space here is enough.
        if (en && !fifo_empt && !buf_full) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = WW'(RD_LATENCY - 1);
        state_d    = (RD_LATENCY == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        if (wait_cnt_q <= WW'(1)) begin
          state_d = CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      fifo_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fifo_rd_q  <= (state_d == ISSUE);
    end
  end

  assign fifo_rd = fifo_rd_q;
  assign busy    = (state_q != IDLE);
  assign push    = (state_q == CAPTURE);
  assign pop     = m_valid && m_ready;

  fifo_rdr_obuf #(
    .DW    (DATA_BUS_SIZE),
    .DEPTH (BUF_DEPTH)
  ) u_obuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (fifo_data),
    .pop_i       (pop),
    .head_o      (m_data),
    .valid_o     (m_valid),
    .full_o      (buf_full)
  );

`ifdef FIFO_RDR_LAST_EN
  localparam int unsigned FW = cnt_width(FRAME_LEN);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          head_is_last;

  assign head_is_last = (frame_cnt_q == FW'(FRAME_LEN - 1));
  assign m_last       = m_valid && head_is_last;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (pop) begin
      frame_cnt_d = head_is_last ? '0 : frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a small FiFo model (2-cycle read path).
// m_last expectations follow FIFO_RDR_LAST_EN with FRAME_LEN=4.
module tb_fifo_reader;

  localparam int FL = 4;
`ifdef FIFO_RDR_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fifo_rd;
  logic        fifo_empt = 1'b1;
  logic [31:0] fifo_data;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        busy;

  always #5 clk = ~clk;

  fifo_reader #(
    .DATA_BUS_SIZE (32),
    .RD_LATENCY    (2),
    .BUF_DEPTH     (2),
    .FRAME_LEN     (FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_rd   (fifo_rd),
    .fifo_empt (fifo_empt),
    .fifo_data (fifo_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy)
  );

  // FiFo model: word registered at the rd edge, then one more stage.
  logic [31:0] fmem [0:63];
  int          fwr = 0;
  int          frd = 0;
  int          underflow = 0;
  logic [31:0] st1 = '0;
  logic [31:0] st2 = '0;
  logic        do_pop;

  assign do_pop    = fifo_rd && (frd < fwr);
  assign fifo_data = st2;

  always @(posedge clk) begin
    if (do_pop) begin
      st1 <= fmem[frd];
      frd <= frd + 1;
    end
    if (fifo_rd && !do_pop) underflow <= underflow + 1;
    st2       <= st1;
    fifo_empt <= ((fwr - frd - (do_pop ? 1 : 0)) == 0);
  end

  // Monitor: records strobes and handshakes; one line per delivered word.
  int          cyc = 0;
  int          rd_cyc [0:63];
  int          rd_n = 0;
  int          valid_cyc = 0;
  logic [31:0] pop_data [0:63];
  logic        pop_last [0:63];
  int          pop_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_rd) begin
      rd_cyc[rd_n] <= cyc;
      rd_n         <= rd_n + 1;
    end
    if (m_valid) valid_cyc <= valid_cyc + 1;
    if (m_valid && m_ready && !rst) begin
      pop_data[pop_n] <= m_data;
      pop_last[pop_n] <= m_last;
      pop_n           <= pop_n + 1;
      $display("pop %0d: data=0x%0h last=%0b", pop_n, m_data, m_last);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_data [0:63];
  logic        exp_last [0:63];
  int          exp_n = 0;
  int          ck = 0;
  int          fc = 0;
  int          base_rd;
  int          base_v;

  task automatic expect_word(input logic [31:0] w);
    exp_data[exp_n] = w;
    fc++;
    exp_last[exp_n] = LAST_EN && (fc == FL);
    if (fc == FL) fc = 0;
    exp_n++;
  endtask

  task automatic load(input logic [31:0] w, input bit expected);
    fmem[fwr] = w;
    fwr++;
    if (expected) expect_word(w);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input string tag);
    int t = 0;
    while (!fifo_rd && t < 20) begin
      tick(1);
      t++;
    end
    check(tag, {31'b0, fifo_rd}, 32'd1);
  endtask

  task automatic verify_pops(input string tag);
    check({tag, "_count"}, pop_n, exp_n);
    while (ck < exp_n && ck < pop_n) begin
      check({tag, "_data"}, pop_data[ck], exp_data[ck]);
      check({tag, "_last"}, {31'b0, pop_last[ck]}, {31'b0, exp_last[ck]});
      ck++;
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_fifo_rd", {31'b0, fifo_rd}, 32'd0);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_last", {31'b0, m_last}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    tick(1);
    rst = 1'b0;

    // Three words, free-flowing downstream: one strobe every 4 cycles
    load(32'h11, 1'b1);
    load(32'h22, 1'b1);
    load(32'h33, 1'b1);
    m_ready = 1'b1;
    tick(2);
    base_rd = rd_n;
    base_v  = valid_cyc;
    en = 1'b1;
    tick(25);
    check("t1_rd_count", rd_n - base_rd, 32'd3);
    check("t1_gap_1", rd_cyc[base_rd + 1] - rd_cyc[base_rd], 32'd4);
    check("t1_gap_2", rd_cyc[base_rd + 2] - rd_cyc[base_rd], 32'd8);
    check("t1_valid_cycles", valid_cyc - base_v, 32'd3);
    verify_pops("t1");

    // Stalled downstream: buffer fills after two reads, head held
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(32'hA0 + i, 1'b1);
    tick(2);
    base_rd = rd_n;
    en = 1'b1;
    tick(30);
    check("t2_rd_stall", rd_n - base_rd, 32'd2);
    @(negedge clk);
    check("t2_valid", {31'b0, m_valid}, 32'd1);
    check("t2_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      @(negedge clk);
      check("t2_hold", m_data, 32'hA0);
    end
    tick(1);
    m_ready = 1'b1;
    tick(40);
    check("t2_rd_total", rd_n - base_rd, 32'd5);
    verify_pops("t2");

    // Toggling ready so captures and pops coincide
    en = 1'b0;
    for (int i = 0; i < 8; i++) load(32'hB0 + i, 1'b1);
    tick(2);
    base_rd = rd_n;
    en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    tick(5);
    check("t3_rd_count", rd_n - base_rd, 32'd8);
    verify_pops("t3");

    // en dropped the cycle after the strobe
    en = 1'b0;
    load(32'hC0, 1'b1);
    load(32'hC1, 1'b0);
    tick(2);
    base_rd = rd_n;
    en = 1'b1;
    wait_rd("t4_strobe");
    tick(1);
    en = 1'b0;
    @(negedge clk);
    check("t4_busy_inflight", {31'b0, busy}, 32'd1);
    tick(10);
    check("t4_rd_held", rd_n - base_rd, 32'd1);
    check("t4_busy_idle", {31'b0, busy}, 32'd0);
    verify_pops("t4a");
    expect_word(32'hC1);
    en = 1'b1;
    tick(10);
    check("t4_rd_resume", rd_n - base_rd, 32'd2);
    verify_pops("t4b");

    // Reset in WAIT abandons the in-flight word
    en = 1'b0;
    load(32'hD0, 1'b0);
    load(32'hD1, 1'b0);
    tick(2);
    en = 1'b1;
    wait_rd("t5_strobe");
    tick(1);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    check("t5_m_valid", {31'b0, m_valid}, 32'd0);
    check("t5_fifo_rd", {31'b0, fifo_rd}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    tick(1);
    rst = 1'b0;
    fc = 0;
    expect_word(32'hD1);
    tick(15);
    verify_pops("t5");

    // Nine words after a fresh reset: frame marker on words 4 and 8
    en = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    fc = 0;
    for (int i = 0; i < 9; i++) load(32'hE0 + i, 1'b1);
    tick(2);
    base_rd = rd_n;
    en = 1'b1;
    tick(50);
    check("t6_rd_count", rd_n - base_rd, 32'd9);
    verify_pops("t6");

    check("fifo_underflow", underflow, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
